alu_result_buffer: RTL and testbench

- Downstream stage of the parametric ALU.
- Captures each ALU result, its upper_result, the seven status flags and the opcode into a registered FIFO with a valid/ready handshake.
- Decouples the combinational ALU from a slower consumer, such as a writeback or trace unit.
- Keeps sticky carry and overflow status and a wrap-around count of accepted operations.

---
 rtl/alu_result_buffer.sv | 138 +++++++++++++
 tb/tb_alu_result_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// Registered FIFO behind the ALU: holds {opcode, result, upper, flags} per entry,
// plus sticky carry/overflow status and a wrap-around count of accepted operations.
module alu_result_buffer #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [5:0]                 in_sel,
  input  logic [N-1:0]               in_result,
  input  logic [N-1:0]               in_upper,
  input  logic [6:0]                 in_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5:0]                 out_sel,
  output logic [N-1:0]               out_result,
  output logic [N-1:0]               out_upper,
  output logic [6:0]                 out_flags,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       sticky_carry,
  output logic                       sticky_ovf,
  input  logic                       sticky_clr,
  output logic [CW-1:0]              op_count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam logic [CNTW-1:0] FULL    = CNTW'(DEPTH);
  localparam logic [PW-1:0]   PTR_MAX = PW'(DEPTH - 1);

  typedef struct packed {
    logic [5:0]   sel;
    logic [N-1:0] result;
    logic [N-1:0] upper;
    logic [6:0]   flags;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          wr_entry;
  entry_t          head;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            sticky_carry_q, sticky_carry_d;
  logic            sticky_ovf_q, sticky_ovf_d;
  logic [CW-1:0]   op_count_q, op_count_d;
  logic            push;
  logic            pop;

  // Ready depends only on registered occupancy, so a full buffer refuses input
  // even while the consumer is popping.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    sticky_carry_d = sticky_carry_q;
    sticky_ovf_d   = sticky_ovf_q;
    op_count_d     = op_count_q;

    if (push) begin
      wr_ptr_d   = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
      op_count_d = op_count_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first, then OR in the current push, so a setting push wins over a clear.
    sticky_carry_d = (sticky_carry_q & ~sticky_clr) | (push & in_flags[0]);
    sticky_ovf_d   = (sticky_ovf_q   & ~sticky_clr) | (push & in_flags[1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      sticky_carry_q <= 1'b0;
      sticky_ovf_q   <= 1'b0;
      op_count_q     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      sticky_carry_q <= sticky_carry_d;
      sticky_ovf_q   <= sticky_ovf_d;
      op_count_q     <= op_count_d;
    end
  end

  always_comb begin
    wr_entry        = '0;
    wr_entry.sel    = in_sel;
    wr_entry.result = in_result;
    wr_entry.upper  = in_upper;
    wr_entry.flags  = in_flags;
  end

  // NOTE: storage is deliberately not reset; occupancy gates every read, so stale
  // contents are never visible and the array can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Head is shown straight from storage; outputs read as zero while empty.
  assign head       = mem_q[rd_ptr_q];
  assign out_sel    = out_valid ? head.sel    : '0;
  assign out_result = out_valid ? head.result : '0;
  assign out_upper  = out_valid ? head.upper  : '0;
  assign out_flags  = out_valid ? head.flags  : '0;

  assign count        = count_q;
  assign sticky_carry = sticky_carry_q;
  assign sticky_ovf   = sticky_ovf_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed scenarios plus random traffic, with a
// queue-based reference model and a decoupled head-entry monitor.
module tb_alu_result_buffer;

  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_sel;
  logic [N-1:0]  in_result;
  logic [N-1:0]  in_upper;
  logic [6:0]    in_flags;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    out_sel;
  logic [N-1:0]  out_result;
  logic [N-1:0]  out_upper;
  logic [6:0]    out_flags;
  logic [2:0]    count;
  logic          sticky_carry;
  logic          sticky_ovf;
  logic          sticky_clr;
  logic [CW-1:0] op_count;

  alu_result_buffer #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sel       (in_sel),
    .in_result    (in_result),
    .in_upper     (in_upper),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sel      (out_sel),
    .out_result   (out_result),
    .out_upper    (out_upper),
    .out_flags    (out_flags),
    .count        (count),
    .sticky_carry (sticky_carry),
    .sticky_ovf   (sticky_ovf),
    .sticky_clr   (sticky_clr),
    .op_count     (op_count)
  );

  typedef struct {
    logic [5:0]   sel;
    logic [N-1:0] res;
    logic [N-1:0] up;
    logic [6:0]   fl;
  } exp_t;

  exp_t sb[$];
  exp_t head_e;

  // Reference model state: occupancy, sticky bits, accepted-operation total.
  int   m_count;
  bit   m_carry;
  bit   m_ovf;
  int   m_ops;

  int   vectors;
  int   miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: verify observable state against the model, drive inputs, then
  // advance the model to what the next rising edge must produce.
  task automatic cycle(input bit v, input bit r, input logic [5:0] sel,
                       input logic [N-1:0] res, input logic [N-1:0] up,
                       input logic [6:0] fl, input bit clr);
    bit   do_push;
    bit   do_pop;
    exp_t e;
    @(negedge clk);
    check("count", 32'(count), 32'(m_count));
    check("in_ready", 32'(in_ready), 32'(m_count != DEPTH));
    check("out_valid", 32'(out_valid), 32'(m_count != 0));
    check("sticky_carry", 32'(sticky_carry), 32'(m_carry));
    check("sticky_ovf", 32'(sticky_ovf), 32'(m_ovf));
    check("op_count", 32'(op_count), 32'(m_ops % (1 << CW)));
    if (m_count == 0) check("empty_out_zero", {out_sel, out_flags, out_result}, 32'd0);

    in_valid   = v;
    out_ready  = r;
    in_sel     = sel;
    in_result  = res;
    in_upper   = up;
    in_flags   = fl;
    sticky_clr = clr;

    do_push = v && (m_count < DEPTH);
    do_pop  = r && (m_count > 0);
    if (do_push) begin
      e.sel = sel; e.res = res; e.up = up; e.fl = fl;
      sb.push_back(e);
      m_ops++;
    end
    if (clr) begin
      m_carry = 1'b0;
      m_ovf   = 1'b0;
    end
    if (do_push && fl[0]) m_carry = 1'b1;
    if (do_push && fl[1]) m_ovf   = 1'b1;
    m_count = m_count + int'(do_push) - int'(do_pop);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(1'b0, r, 6'd0, '0, '0, 7'd0, 1'b0);
  endtask

  // Reset asserted mid-high-phase, after the previous edge has completed.
  task automatic do_reset();
    @(posedge clk);
    #2;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sticky", {sticky_carry, sticky_ovf}, 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_out_data", {out_sel, out_flags, out_result}, 32'd0);
    check("rst_out_upper", 32'(out_upper), 32'd0);
    sb.delete();
    m_count = 0;
    m_carry = 1'b0;
    m_ovf   = 1'b0;
    m_ops   = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: whenever the DUT offers a head that the consumer takes, it must be
  // the oldest outstanding expected entry.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pop: got result %0h, expected no entry", out_result);
      end else begin
        head_e = sb.pop_front();
        check("head_sel", 32'(out_sel), 32'(head_e.sel));
        check("head_result", 32'(out_result), 32'(head_e.res));
        check("head_upper", 32'(out_upper), 32'(head_e.up));
        check("head_flags", 32'(out_flags), 32'(head_e.fl));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_sel      = '0;
    in_result   = '0;
    in_upper    = '0;
    in_flags    = '0;
    sticky_clr  = 1'b0;
    do_reset();

    // Fill and drain, with a rejected fifth push while full.
    cycle(1, 0, 6'd0, 16'h0001, 16'h0000, 7'd0, 0);
    cycle(1, 0, 6'd1, 16'hFFFF, 16'h0000, 7'd0, 0);
    cycle(1, 0, 6'd2, 16'h8000, 16'h0000, 7'd0, 0);
    cycle(1, 0, 6'd3, 16'h1234, 16'h0000, 7'd0, 0);
    cycle(1, 0, 6'd4, 16'hDEAD, 16'hBEEF, 7'd0, 0);
    idle(1, 0);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_op_count", 32'(op_count), 32'd4);
    idle(5, 1);
    check("drained_out_valid", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at count 2 across the pointer wrap.
    cycle(1, 0, 6'd10, 16'd50, 16'h1111, 7'd0, 0);
    cycle(1, 0, 6'd11, 16'd51, 16'h2222, 7'd0, 0);
    for (int i = 0; i < 6; i++)
      cycle(1, 1, 6'(20 + i), 16'(100 + i), 16'(i), 7'd0, 0);
    idle(1, 0);
    check("pushpop_count", 32'(count), 32'd2);
    idle(3, 1);

    // Sticky flags: set, clear-with-set-push, clear alone.
    cycle(1, 1, 6'd5, 16'h0A0A, 16'h0, 7'b0000001, 0);
    cycle(1, 1, 6'd6, 16'h0B0B, 16'h0, 7'b0000010, 0);
    idle(1, 1);
    check("sticky_both_set", {sticky_carry, sticky_ovf}, 32'd3);
    cycle(1, 1, 6'd7, 16'h0C0C, 16'h0, 7'b0000001, 1);
    idle(1, 1);
    check("sticky_clr_push", {sticky_carry, sticky_ovf}, 32'd2);
    cycle(0, 1, 6'd0, 16'h0, 16'h0, 7'd0, 1);
    idle(2, 1);
    check("sticky_clr_alone", {sticky_carry, sticky_ovf}, 32'd0);

    // Latency on empty: no bypass, visible only after the push edge.
    cycle(1, 1, 6'd9, 16'h5A5A, 16'hA5A5, 7'b1010101, 0);
    idle(3, 1);

    // Reset mid-operation at count 3, sticky set, op_count 7.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 6'(i), 16'(200 + i), 16'h0, 7'd0, 0);
    idle(1, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 6'(i), 16'(300 + i), 16'h0, 7'b0000011, 0);
    idle(1, 0);
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_op_count", 32'(op_count), 32'd7);
    do_reset();
    cycle(1, 0, 6'd33, 16'hCAFE, 16'h0F0F, 7'b0100000, 0);
    idle(3, 1);

    // op_count wraps modulo 2^CW.
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1, 1, 6'(i), 16'(i * 3), 16'(i), 7'd0, 0);
    idle(3, 1);
    check("op_count_wrap", 32'(op_count), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            6'($urandom), 16'($urandom), 16'($urandom), 7'($urandom),
            ($urandom_range(0, 7) == 0));
    idle(DEPTH + 2, 1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
